// File: rtl/lemming_world.sv
// Grid world for a single lemming: stores a solid/air map, moves the lemming
// according to its one-hot activity inputs and produces its sensor inputs.
module lemming_world #(
  parameter int unsigned COLS       = 16,
  parameter int unsigned ROWS       = 8,
  parameter int unsigned DIG_CYCLES = 4,
  parameter int unsigned START_COL  = 8
) (
  input  logic                    clk,
  input  logic                    areset,
  input  logic                    step,
  input  logic                    walk_left,
  input  logic                    walk_right,
  input  logic                    aaah,
  input  logic                    digging,
  input  logic                    cfg_we,
  input  logic [$clog2(ROWS)-1:0] cfg_row,
  input  logic [$clog2(COLS)-1:0] cfg_col,
  input  logic                    cfg_solid,
  output logic                    ground,
  output logic                    bump_left,
  output logic                    bump_right,
  output logic [$clog2(ROWS)-1:0] lem_row,
  output logic [$clog2(COLS)-1:0] lem_col,
  output logic [4:0]              fall_len,
  output logic                    err
);

  localparam int unsigned RW = $clog2(ROWS);
  localparam int unsigned CW = $clog2(COLS);
  localparam int unsigned DW = (DIG_CYCLES > 1) ? $clog2(DIG_CYCLES) : 1;

  logic [COLS-1:0] solid [ROWS];
  logic [DW-1:0]   dig_cnt;

  logic          at_bottom, at_left, at_right;
  logic [RW-1:0] row_dn;
  logic [CW-1:0] col_l, col_r;
  logic          do_fall, do_dig, dig_last, do_left, do_right;
  logic          multi_act, cfg_hit;

  // Neighbour indices are clamped at the edges so the grid is never indexed
  // out of range; the edge flags override the clamped lookup.
  always_comb begin
    at_bottom  = (32'(lem_row) == ROWS - 1);
    at_left    = (lem_col == '0);
    at_right   = (32'(lem_col) == COLS - 1);
    row_dn     = at_bottom ? lem_row : lem_row + RW'(1);
    col_l      = at_left   ? lem_col : lem_col - CW'(1);
    col_r      = at_right  ? lem_col : lem_col + CW'(1);
    ground     = at_bottom | solid[row_dn][lem_col];
    bump_left  = at_left   | solid[lem_row][col_l];
    bump_right = at_right  | solid[lem_row][col_r];
  end

  always_comb begin
    do_fall   = aaah & ~ground;
    do_dig    = ~aaah & digging & ground & ~at_bottom;
    dig_last  = do_dig & (32'(dig_cnt) == DIG_CYCLES - 1);
    do_left   = ~aaah & ~digging & walk_left & ground & ~bump_left;
    do_right  = ~aaah & ~digging & ~walk_left & walk_right & ground & ~bump_right;
    multi_act = (aaah & digging) | (aaah & walk_left) | (aaah & walk_right) |
                (digging & walk_left) | (digging & walk_right) |
                (walk_left & walk_right);
    cfg_hit   = cfg_we & (32'(cfg_row) < ROWS) & (32'(cfg_col) < COLS);
  end

  // The cfg write is issued after the dig-clear so it wins on the same cell.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      for (int unsigned r = 0; r < ROWS; r++) solid[r] <= '0;
    end else begin
      if (step && dig_last) solid[row_dn][lem_col] <= 1'b0;
      if (cfg_hit) solid[cfg_row][cfg_col] <= cfg_solid;
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      lem_row  <= '0;
      lem_col  <= CW'(START_COL);
      dig_cnt  <= '0;
      fall_len <= '0;
      err      <= 1'b0;
    end else if (step) begin
      if (multi_act) err <= 1'b1;
      if (do_fall) lem_row <= row_dn;
      if (do_left) lem_col <= col_l;
      else if (do_right) lem_col <= col_r;
      if (!aaah) fall_len <= '0;
      else if (do_fall && fall_len != 5'd31) fall_len <= fall_len + 5'd1;
      if (!do_dig || dig_last) dig_cnt <= '0;
      else dig_cnt <= dig_cnt + DW'(1);
    end
  end

endmodule

// File: tb/tb_lemming_world.sv
// Directed bench for lemming_world: an integer grid model is checked against
// the outputs every cycle, plus literal expectations after each scenario.
module tb_lemming_world;
  localparam int COLS = 16;
  localparam int ROWS = 8;
  localparam int DIG  = 4;
  localparam int SCOL = 8;

  logic       clk = 1'b0;
  logic       areset, step, walk_left, walk_right, aaah, digging;
  logic       cfg_we, cfg_solid;
  logic [2:0] cfg_row;
  logic [3:0] cfg_col;
  logic       ground, bump_left, bump_right, err;
  logic [2:0] lem_row;
  logic [3:0] lem_col;
  logic [4:0] fall_len;

  int checks = 0;
  int failures = 0;

  lemming_world #(.COLS(COLS), .ROWS(ROWS), .DIG_CYCLES(DIG), .START_COL(SCOL)) dut (
    .clk(clk), .areset(areset), .step(step), .walk_left(walk_left),
    .walk_right(walk_right), .aaah(aaah), .digging(digging), .cfg_we(cfg_we),
    .cfg_row(cfg_row), .cfg_col(cfg_col), .cfg_solid(cfg_solid),
    .ground(ground), .bump_left(bump_left), .bump_right(bump_right),
    .lem_row(lem_row), .lem_col(lem_col), .fall_len(fall_len), .err(err)
  );

  always #5 clk = ~clk;

  // Model state
  int m_solid [ROWS][COLS];
  int m_row, m_col, m_dig, m_fall, m_err;

  function automatic int m_ground();
    return (m_row == ROWS - 1 || m_solid[m_row+1][m_col] != 0) ? 1 : 0;
  endfunction
  function automatic int m_bl();
    return (m_col == 0 || m_solid[m_row][m_col-1] != 0) ? 1 : 0;
  endfunction
  function automatic int m_br();
    return (m_col == COLS - 1 || m_solid[m_row][m_col+1] != 0) ? 1 : 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge areset) begin : model
    int g, bl, br, nact;
    if (areset) begin
      foreach (m_solid[r, c]) m_solid[r][c] = 0;
      m_row = 0; m_col = SCOL; m_dig = 0; m_fall = 0; m_err = 0;
    end else begin
      g = m_ground(); bl = m_bl(); br = m_br();
      if (step) begin
        nact = int'(aaah) + int'(digging) + int'(walk_left) + int'(walk_right);
        if (nact > 1) m_err = 1;
        if (aaah) begin
          m_dig = 0;
          if (g == 0) begin
            m_row++;
            if (m_fall < 31) m_fall++;
          end
        end else begin
          m_fall = 0;
          if (digging) begin
            if (g == 1 && m_row < ROWS - 1) begin
              m_dig++;
              if (m_dig == DIG) begin
                m_solid[m_row+1][m_col] = 0;
                m_dig = 0;
              end
            end else m_dig = 0;
          end else begin
            m_dig = 0;
            if (walk_left) begin
              if (g == 1 && bl == 0) m_col--;
            end else if (walk_right) begin
              if (g == 1 && br == 0) m_col++;
            end
          end
        end
      end
      if (cfg_we) m_solid[cfg_row][cfg_col] = cfg_solid ? 1 : 0;
    end
  end

  always @(negedge clk) begin
    if (!areset) begin
      chk("ground", int'(ground), m_ground());
      chk("bump_left", int'(bump_left), m_bl());
      chk("bump_right", int'(bump_right), m_br());
      chk("lem_row", int'(lem_row), m_row);
      chk("lem_col", int'(lem_col), m_col);
      chk("fall_len", int'(fall_len), m_fall);
      chk("err", int'(err), m_err);
    end
  end

  // Inputs applied for exactly one rising edge, then cleared.
  task automatic tick();
    @(posedge clk); #1;
    step = 0; walk_left = 0; walk_right = 0; aaah = 0; digging = 0;
    cfg_we = 0; cfg_solid = 0; cfg_row = '0; cfg_col = '0;
    @(negedge clk); #1;
  endtask

  task automatic act(input logic s, input logic a, input logic d,
                     input logic l, input logic r, input int n);
    for (int i = 0; i < n; i++) begin
      step = s; aaah = a; digging = d; walk_left = l; walk_right = r;
      tick();
    end
  endtask

  task automatic wr(input int r, input int c, input logic v);
    cfg_we = 1; cfg_row = 3'(r); cfg_col = 4'(c); cfg_solid = v;
    tick();
  endtask

  task automatic rst();
    areset = 1; #2; areset = 0;
  endtask

  task automatic fill_row1();
    for (int c = 0; c < COLS; c++) wr(1, c, 1'b1);
  endtask

  initial begin
    areset = 0; step = 0; walk_left = 0; walk_right = 0; aaah = 0; digging = 0;
    cfg_we = 0; cfg_solid = 0; cfg_row = '0; cfg_col = '0;
    #1 areset = 1;
    @(negedge clk); #1; areset = 0;

    chk("rst_row", int'(lem_row), 0);
    chk("rst_col", int'(lem_col), 8);
    chk("rst_ground", int'(ground), 0);
    chk("rst_err", int'(err), 0);

    // Free fall to bedrock
    act(1, 1, 0, 0, 0, 7);
    chk("fall_row", int'(lem_row), 7);
    chk("fall_ground", int'(ground), 1);
    chk("fall_len7", int'(fall_len), 7);
    act(1, 1, 0, 0, 0, 1);
    chk("fall_hold", int'(fall_len), 7);
    act(1, 0, 0, 0, 0, 1);
    chk("fall_clear", int'(fall_len), 0);
    act(1, 0, 1, 0, 0, 5);
    chk("bedrock_dig", int'(ground), 1);

    // Walk left to the wall
    rst(); fill_row1();
    act(1, 0, 0, 1, 0, 10);
    chk("wl_col", int'(lem_col), 0);
    chk("wl_bump", int'(bump_left), 1);
    chk("wl_err", int'(err), 0);

    // Walk right into a block
    rst(); fill_row1(); wr(0, 10, 1'b1);
    act(1, 0, 0, 0, 1, 3);
    chk("wr_col", int'(lem_col), 9);
    chk("wr_bump", int'(bump_right), 1);

    // Dig through and fall
    rst(); fill_row1();
    act(1, 0, 1, 0, 0, 3);
    chk("dig3_ground", int'(ground), 1);
    act(1, 0, 1, 0, 0, 1);
    chk("dig4_ground", int'(ground), 0);
    act(1, 1, 0, 0, 0, 7);
    chk("digfall_row", int'(lem_row), 7);
    chk("digfall_len", int'(fall_len), 7);

    // Dig interrupted by step=0 pauses, then reset mid-dig
    rst(); fill_row1();
    act(1, 0, 1, 0, 0, 2);
    act(0, 0, 1, 0, 0, 3);
    act(1, 0, 1, 0, 0, 1);
    chk("pause_dig3", int'(ground), 1);
    act(1, 0, 1, 0, 0, 1);
    chk("pause_dig4", int'(ground), 0);
    fill_row1();
    act(1, 0, 1, 0, 0, 2);
    rst();
    chk("mid_rst_col", int'(lem_col), 8);
    chk("mid_rst_grid", int'(ground), 0);
    fill_row1();
    act(1, 0, 1, 0, 0, 3);
    chk("mid_rst_cnt", int'(ground), 1);

    // cfg write beats dig-clear on the same cell
    rst(); fill_row1();
    act(1, 0, 1, 0, 0, 3);
    step = 1; digging = 1; cfg_we = 1; cfg_row = 3'd1; cfg_col = 4'd8; cfg_solid = 1;
    tick();
    chk("collide_ground", int'(ground), 1);
    act(1, 0, 1, 0, 0, 1);
    chk("collide_cnt0", int'(ground), 1);

    // Illegal activity combinations
    act(0, 0, 0, 1, 1, 1);
    chk("err_step0", int'(err), 0);
    act(1, 0, 0, 1, 1, 1);
    chk("err_col", int'(lem_col), 7);
    chk("err_set", int'(err), 1);
    act(1, 0, 0, 0, 0, 2);
    chk("err_sticky", int'(err), 1);
    act(1, 1, 1, 0, 0, 1);
    chk("aaah_prio_row", int'(lem_row), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lemming_world.md
Name: lemming_world

Overview:
- Terrain/world model that closes the loop around the lemming behaviour FSM.
- Consumes the FSM's one-hot activity outputs (walk_left, walk_right, aaah, digging) and moves a single lemming through a 2-D solid/air grid.
- Produces the FSM's sensor inputs: ground, bump_left, bump_right.
- Also reports position and fall length to the bench and scoreboard.

Parameters:
- COLS, 16, grid width in columns (>=2); col 0 is leftmost.
- ROWS, 8, grid height in rows (>=2); row 0 is top, row ROWS-1 is bedrock level.
- DIG_CYCLES, 4, consecutive digging steps needed to remove the floor cell (>=1).
- START_COL, 8, lemming column after reset (<COLS).

Ports:
- clk  in  1  clock
- areset  in  1  asynchronous active-high reset
- step  in  1  advance simulation one tick; 0 freezes lemming state (cfg writes still apply)
- walk_left  in  1  from FSM
- walk_right  in  1  from FSM
- aaah  in  1  from FSM
- digging  in  1  from FSM
- cfg_we  in  1  grid write strobe
- cfg_row  in  $clog2(ROWS)  grid write row
- cfg_col  in  $clog2(COLS)  grid write column
- cfg_solid  in  1  value written (1=solid)
- ground  out  1  lemming stands on solid
- bump_left  out  1  blocked on left
- bump_right  out  1  blocked on right
- lem_row  out  $clog2(ROWS)  current row
- lem_col  out  $clog2(COLS)  current column
- fall_len  out  5  rows fallen in current fall, saturates at 31
- err  out  1  sticky: illegal (non-one-hot, nonzero) activity inputs seen on a step

Behaviour:
- Storage:
  - solid[ROWS][COLS] register grid.
  - lem_row, lem_col, dig_cnt (counts 0..DIG_CYCLES-1), fall_len, err.
- Reset (async): grid all 0, lem_row=0, lem_col=START_COL, dig_cnt=0, fall_len=0, err=0.
- Sensor outputs are combinational from registered position and grid (zero latency):
  - ground = (lem_row==ROWS-1) | solid[lem_row+1][lem_col].
  - bump_left = (lem_col==0) | solid[lem_row][lem_col-1].
  - bump_right = (lem_col==COLS-1) | solid[lem_row][lem_col+1].
  - Solid in the lemming's own cell is ignored for all sensing.
- Activity priority when step=1: aaah > digging > walk_left > walk_right.
- If more than one activity input is high, err<=1 (sticky until reset) and the highest-priority input is acted on.
- Per step=1 tick, using current-cycle sensors:
  - aaah & !ground: lem_row+1; fall_len+1 (saturating).
  - aaah & ground: no move; fall_len held.
  - digging & ground & lem_row<ROWS-1: dig_cnt+1.
    - When dig_cnt==DIG_CYCLES-1, clear solid[lem_row+1][lem_col] and set dig_cnt=0.
    - ground therefore falls to 0 the cycle after the DIG_CYCLES-th digging step.
  - digging at bedrock (lem_row==ROWS-1): no effect; dig_cnt stays 0.
  - walk_left & ground & !bump_left: lem_col-1.
  - walk_right & ground & !bump_right: lem_col+1.
  - A blocked walk or a walk with !ground: no move.
  - Any step where digging is not acted on: dig_cnt=0.
  - fall_len clears to 0 on any step where aaah is low.
  - No activity input high: position held.
- step=0: lem_row, lem_col, dig_cnt, fall_len, err all hold; walk/aaah/digging ignored.
- cfg_we:
  - Applied on any cycle regardless of step; out-of-range row/col is dropped.
  - If a dig-clear and a cfg write hit the same cell in the same cycle, the cfg write wins.
  - Writing the lemming's own cell is legal and has no effect on sensing.
- Position never wraps: all moves are gated by the edge/bump conditions above.

Test Plan:
- Reset, empty grid, step=1, aaah held -> lem_row steps 0..7 over 7 cycles; ground=1 at row 7; fall_len=7; next step with aaah low -> fall_len=0.
- Row 1 all solid, walk_left held 10 steps from col 8 -> lem_col 8,7..0 then holds 0; bump_left=1 at col 0; err=0.
- Row 1 solid plus solid[0][10], walk_right from col 8 -> lem_col=9, bump_right=1, lem_col stays 9 on following steps.
- Row 1 solid, digging held 4 steps at (0,8) -> solid[1][8]=0 after 4th step; ground=0 next cycle; aaah then moves lem_row to 7; fall_len=7.
- Digging 2 steps, step=0 for 3 cycles, then 2 more digging steps -> floor cleared only after the 4th effective step; areset mid-dig -> dig_cnt=0, grid cleared, lem_col=8.
- walk_left and walk_right high together, ground=1 -> moves left one column, err=1 and stays 1; cfg_we to solid[1][8] in the same cycle as a dig-clear of that cell -> cell remains solid.
